// File: rtl/dlf16_to_int_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dlf16_to_int_pipe                                                        |
// | 3-stage DLFloat16 -> signed INT_W converter, valid/ready, 4 rounding     |
// | modes, saturation. Flags built only with DLF16_TO_INT_FLAGS_EN defined.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dlf16_to_int_pipe #(
  parameter int INT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic [1:0]       in_rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_data,
  output logic             out_invalid,
  output logic             out_inexact
);

  localparam logic [1:0] c_cls_zero = 2'd0;
  localparam logic [1:0] c_cls_norm = 2'd1;
  localparam logic [1:0] c_cls_spec = 2'd2;

  localparam logic [64:0]      c_pos_lim = (65'd1 << (INT_W - 1)) - 65'd1;
  localparam logic [64:0]      c_neg_lim = 65'd1 << (INT_W - 1);
  localparam logic [INT_W-1:0] c_max     = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] c_min     = {1'b1, {(INT_W-1){1'b0}}};

  logic              r1_valid, r2_valid, r3_valid;
  logic              r1_sign, r2_sign;
  logic [1:0]        r1_cls, r2_cls, r1_rm;
  logic signed [6:0] r1_exp;
  logic [9:0]        r1_sig;
  logic [32:0]       r2_mag;
  logic [INT_W-1:0]  r3_data;

  logic              w_ready2, w_ready3;
  logic [32:0]       w_mag, w_rmag;
  logic              w_guard, w_sticky, w_inc;
  logic [4:0]        w_shl;
  logic [3:0]        w_shr;
  logic [INT_W-1:0]  w_mag_int, w_data;
  logic              w_ovf;

  // Ready ripples back from the consumer so a full pipe still streams.
  assign w_ready3  = !r3_valid || out_ready;
  assign w_ready2  = !r2_valid || w_ready3;
  assign in_ready  = !r1_valid || w_ready2;
  assign out_valid = r3_valid;
  assign out_data  = r3_data;

  always_comb begin
    w_mag    = '0;
    w_guard  = 1'b0;
    w_sticky = 1'b0;
    w_shl    = 5'd0;
    w_shr    = 4'd0;
    if (r1_cls == c_cls_norm) begin
      if (r1_exp >= 7'sd9) begin
        w_shl = 5'(r1_exp - 7'sd9);
        w_mag = {23'd0, r1_sig} << w_shl;
      end else if (r1_exp >= 7'sd0) begin
        w_shr    = 4'(7'sd9 - r1_exp);
        w_mag    = {23'd0, r1_sig >> w_shr};
        w_guard  = r1_sig[w_shr - 4'd1];
        w_sticky = |(r1_sig & ((10'd1 << (w_shr - 4'd1)) - 10'd1));
      end else begin
        w_guard  = (r1_exp == -7'sd1);
        w_sticky = (r1_exp < -7'sd1) ? 1'b1 : |r1_sig[8:0];
      end
    end
    case (r1_rm)
      2'b00:   w_inc = w_guard && (w_sticky || w_mag[0]);
      2'b01:   w_inc = 1'b0;
      2'b10:   w_inc = r1_sign && (w_guard || w_sticky);
      default: w_inc = !r1_sign && (w_guard || w_sticky);
    endcase
    w_rmag = w_mag + 33'(w_inc);
  end

  always_comb begin
    w_mag_int = INT_W'(r2_mag);
    w_data    = r2_sign ? -w_mag_int : w_mag_int;
    w_ovf     = 1'b0;
    if (r2_cls == c_cls_spec) begin
      w_ovf = 1'b1;
    end else if (r2_cls == c_cls_zero) begin
      w_data = '0;
    end else if (!r2_sign && ({32'd0, r2_mag} > c_pos_lim)) begin
      w_ovf = 1'b1;
    end else if (r2_sign && ({32'd0, r2_mag} > c_neg_lim)) begin
      w_ovf = 1'b1;
    end
    if (w_ovf) begin
      w_data = r2_sign ? c_min : c_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_cls   <= c_cls_zero;
      r1_exp   <= '0;
      r1_sig   <= '0;
      r1_rm    <= '0;
      r2_valid <= 1'b0;
      r2_sign  <= 1'b0;
      r2_cls   <= c_cls_zero;
      r2_mag   <= '0;
      r3_valid <= 1'b0;
      r3_data  <= '0;
    end else begin
      if (in_ready) r1_valid <= in_valid;
      if (in_valid && in_ready) begin
        r1_sign <= in_data[15];
        r1_cls  <= (in_data[14:9] == 6'd0)  ? c_cls_zero :
                   (in_data[14:9] == 6'd63) ? c_cls_spec : c_cls_norm;
        r1_exp  <= $signed({1'b0, in_data[14:9]}) - 7'sd31;
        r1_sig  <= {1'b1, in_data[8:0]};
        r1_rm   <= in_rm;
      end
      if (w_ready2) r2_valid <= r1_valid;
      if (r1_valid && w_ready2) begin
        r2_sign <= r1_sign;
        r2_cls  <= r1_cls;
        r2_mag  <= w_rmag;
      end
      if (w_ready3) r3_valid <= r2_valid;
      if (r2_valid && w_ready3) r3_data <= w_data;
    end
  end

`ifdef DLF16_TO_INT_FLAGS_EN
  logic r2_inexact, r3_invalid, r3_inexact;
  logic w_inx;

  assign w_inx = r2_inexact && !w_ovf && (r2_cls == c_cls_norm);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_inexact <= 1'b0;
      r3_invalid <= 1'b0;
      r3_inexact <= 1'b0;
    end else begin
      if (r1_valid && w_ready2) r2_inexact <= w_guard || w_sticky;
      if (r2_valid && w_ready3) begin
        r3_invalid <= w_ovf;
        r3_inexact <= w_inx;
      end
    end
  end

  assign out_invalid = r3_invalid;
  assign out_inexact = r3_inexact;
`else
  assign out_invalid = 1'b0;
  assign out_inexact = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dlf16_to_int_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dlf16_to_int_pipe                                                     |
// | Bench for dlf16_to_int_pipe at INT_W=32 and INT_W=64 side by side.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_dlf16_to_int_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_data = '0;
  logic [1:0]  in_rm = '0;
  logic        rdy32, rdy64, ov32, ov64, inv32, inv64, inx32, inx64;
  logic [31:0] od32;
  logic [63:0] od64;

  always #5 clk = ~clk;

`ifdef DLF16_TO_INT_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  dlf16_to_int_pipe #(.INT_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .in_data(in_data), .in_rm(in_rm), .out_valid(ov32), .out_ready(out_ready),
    .out_data(od32), .out_invalid(inv32), .out_inexact(inx32));

  dlf16_to_int_pipe #(.INT_W(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
    .in_data(in_data), .in_rm(in_rm), .out_valid(ov64), .out_ready(out_ready),
    .out_data(od64), .out_invalid(inv64), .out_inexact(inx64));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int mode    = 0;

  typedef struct {
    logic [31:0] d32;
    logic        i32, x32;
    logic [63:0] d64;
    logic        i64, x64;
    int          c;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [15:0] d;
    logic [1:0]  rm;
    int          w;
    logic [63:0] r;
    logic        inv, inx;
  } pin_t;

  pin_t pins [17] = '{
    '{16'h3E00, 2'd0, 32, 64'd1,                  1'b0, 1'b0},
    '{16'h3F00, 2'd0, 32, 64'd2,                  1'b0, 1'b1},
    '{16'h4080, 2'd0, 32, 64'd2,                  1'b0, 1'b1},
    '{16'h3D00, 2'd0, 32, 64'd1,                  1'b0, 1'b1},
    '{16'hC080, 2'd1, 32, 64'hFFFFFFFFFFFFFFFE,   1'b0, 1'b1},
    '{16'hC080, 2'd2, 32, 64'hFFFFFFFFFFFFFFFD,   1'b0, 1'b1},
    '{16'hC080, 2'd3, 32, 64'hFFFFFFFFFFFFFFFE,   1'b0, 1'b1},
    '{16'hC080, 2'd0, 32, 64'hFFFFFFFFFFFFFFFE,   1'b0, 1'b1},
    '{16'h3C00, 2'd3, 32, 64'd1,                  1'b0, 1'b1},
    '{16'h3C00, 2'd0, 32, 64'd0,                  1'b0, 1'b1},
    '{16'h3C00, 2'd2, 32, 64'd0,                  1'b0, 1'b1},
    '{16'h7C00, 2'd0, 32, 64'h000000007FFFFFFF,   1'b1, 1'b0},
    '{16'hFC00, 2'd0, 32, 64'hFFFFFFFF80000000,   1'b0, 1'b0},
    '{16'h7FFF, 2'd0, 32, 64'h000000007FFFFFFF,   1'b1, 1'b0},
    '{16'hFFFF, 2'd0, 32, 64'hFFFFFFFF80000000,   1'b1, 1'b0},
    '{16'h0123, 2'd0, 32, 64'd0,                  1'b0, 1'b0},
    '{16'h7C00, 2'd0, 64, 64'h0000000080000000,   1'b0, 1'b0}
  };

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Exact value in units of 2^-39, then rounded and range-limited as plain integers.
  function automatic void model(input logic [15:0] d, input logic [1:0] rm, input int w,
                                output logic [63:0] res, output logic inv, output logic inx);
    logic        s;
    int          e;
    logic [79:0] x, ip, fr, half, mag, lim;
    s   = d[15];
    e   = int'(d[14:9]);
    inv = 1'b0;
    inx = 1'b0;
    res = '0;
    lim = 80'd1 << (w - 1);
    if (e == 63) begin
      inv = 1'b1;
      res = s ? 64'(-lim) : 64'(lim - 80'd1);
    end else if (e != 0) begin
      x    = {70'd0, 1'b1, d[8:0]} << (e - 1);
      ip   = x >> 39;
      fr   = x & ((80'd1 << 39) - 80'd1);
      half = 80'd1 << 38;
      mag  = ip;
      case (rm)
        2'd0: if (fr > half || (fr == half && ip[0])) mag = ip + 80'd1;
        2'd2: if (s && fr != 0) mag = ip + 80'd1;
        2'd3: if (!s && fr != 0) mag = ip + 80'd1;
        default: ;
      endcase
      if ((!s && mag > lim - 80'd1) || (s && mag > lim)) begin
        inv = 1'b1;
        res = s ? 64'(-lim) : 64'(lim - 80'd1);
      end else begin
        res = s ? 64'(-mag) : 64'(mag);
        inx = (fr != 0);
      end
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      2:       out_ready = !out_ready;
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  exp_t        ce;
  logic [63:0] cr;
  logic        ci, cx, exp_v, exp_rdy;

  // Scoreboard: FIFO order, 3-cycle minimum residence, capacity 3.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid32", {63'd0, ov32}, 64'd0);
      chk("rst_out_valid64", {63'd0, ov64}, 64'd0);
      chk("rst_out_data32", {32'd0, od32}, 64'd0);
      q.delete();
    end else begin
      exp_rdy = (q.size() < 3) || out_ready;
      exp_v   = (q.size() != 0) && (cyc - q[0].c >= 3);
      chk("in_ready32", {63'd0, rdy32}, {63'd0, exp_rdy});
      chk("in_ready64", {63'd0, rdy64}, {63'd0, exp_rdy});
      chk("out_valid32", {63'd0, ov32}, {63'd0, exp_v});
      chk("out_valid64", {63'd0, ov64}, {63'd0, exp_v});
      if (exp_v) begin
        ce = q[0];
        chk("data32", {32'd0, od32}, {32'd0, ce.d32});
        chk("invalid32", {63'd0, inv32}, {63'd0, ce.i32});
        chk("inexact32", {63'd0, inx32}, {63'd0, ce.x32});
        chk("data64", od64, ce.d64);
        chk("invalid64", {63'd0, inv64}, {63'd0, ce.i64});
        chk("inexact64", {63'd0, inx64}, {63'd0, ce.x64});
        if (out_ready) q.delete(0);
      end
      if (in_valid && exp_rdy) begin
        model(in_data, in_rm, 32, cr, ci, cx);
        ce.d32 = cr[31:0];
        ce.i32 = ci && FL;
        ce.x32 = cx && FL;
        model(in_data, in_rm, 64, cr, ci, cx);
        ce.d64 = cr;
        ce.i64 = ci && FL;
        ce.x64 = cx && FL;
        ce.c   = cyc;
        q.push_back(ce);
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic [1:0] rm);
    int  n;
    bit  acc;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_rm    = rm;
    forever begin
      @(negedge clk);
      acc = rdy32;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 64'(n), 64'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [15:0] rnd_op();
    logic [15:0] d;
    d = 16'($urandom);
    case ($urandom_range(0, 3))
      0: ;
      1: d[14:9] = 6'($urandom_range(25, 41));
      2: d[14:9] = 6'($urandom_range(55, 63));
      default: d[14:9] = ($urandom_range(0, 1) != 0) ? 6'd0 : 6'd62;
    endcase
    return d;
  endfunction

  logic [63:0] pr;
  logic        pi, px;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_out_valid", {63'd0, ov32}, 64'd0);
    chk("post_rst_out_data", {32'd0, od32}, 64'd0);
    chk("post_rst_flags", {62'd0, inv32, inx32}, 64'd0);
    chk("post_rst_in_ready", {63'd0, rdy32}, 64'd1);

    foreach (pins[i]) begin
      model(pins[i].d, pins[i].rm, pins[i].w, pr, pi, px);
      chk($sformatf("pin%0d_val", i), pr, pins[i].r);
      chk($sformatf("pin%0d_inv", i), {63'd0, pi}, {63'd0, pins[i].inv});
      chk($sformatf("pin%0d_inx", i), {63'd0, px}, {63'd0, pins[i].inx});
    end

    // Directed vectors streamed back-to-back.
    foreach (pins[i]) begin
      if (pins[i].w == 32) send(pins[i].d, pins[i].rm);
    end
    drain();

    // Backpressure: fill to capacity, then release every other cycle.
    mode = 1;
    idle(1);
    send(16'h3E00, 2'd0);
    send(16'h3F00, 2'd0);
    send(16'h4080, 2'd0);
    @(negedge clk);
    chk("full_in_ready", {63'd0, rdy32}, 64'd0);
    @(posedge clk);
    #1;
    mode = 2;
    send(16'hC080, 2'd2);
    send(16'h7C00, 2'd0);
    drain();

    // Mid-stream reset with two operands in flight.
    mode = 1;
    idle(1);
    send(16'h4100, 2'd0);
    send(16'hC200, 2'd1);
    @(posedge clk);
    #1;
    chk("pre_reset_valid", {63'd0, ov32}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_out_valid", {63'd0, ov32}, 64'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mode  = 0;
    idle(6);
    chk("reset_in_ready", {63'd0, rdy32}, 64'd1);

    // Random operands under random backpressure and gaps.
    mode = 3;
    for (int i = 0; i < 400; i++) begin
      send(rnd_op(), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
    end
    mode = 0;
    drain();

    // Full-rate streaming.
    for (int i = 0; i < 120; i++) send(rnd_op(), 2'($urandom_range(0, 3)));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dlf16_to_int_pipe.md
# dlf16_to_int_pipe

Pipelined, parametrised DLFloat16-to-signed-integer converter for the FPU datapath. It accepts DLFloat16 operands through a valid/ready handshake and supports four IEEE rounding modes. Out-of-range results saturate, and invalid and inexact exception flags are reported. Its output is an integer of configurable width. It replaces the combinational truncating converter wherever the conversion result feeds registered logic.

## Interface
- `INT_W`, default 32: output integer width; legal range 16..64.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: an input operand is present.
- `in_ready` output 1: the block can accept an operand this cycle.
- `in_data` input 16: DLFloat16 operand: sign [15], exponent [14:9] with bias 31, fraction [8:0].
- `in_rm` input 2: rounding mode, travels with the operand: 00 RNE, 01 RTZ, 10 RDN (toward −inf), 11 RUP (toward +inf).
- `out_valid` output 1: a result is present.
- `out_ready` input 1: the consumer accepts the result.
- `out_data` output INT_W: two's-complement result.
- `out_invalid` output 1: the operand was exp==63, or the result overflowed.
- `out_inexact` output 1: discarded fraction bits were nonzero, and the result did not saturate.

## Operation
- Transfer occurs when valid && ready on the same edge, for both the in and out ports.
- Stage 1 (decode) registers the following:
  - sign;
  - the class, one of zero (exp==0, fraction ignored, no denormals), special (exp==63), or normal;
  - unbiased E = exp−31, in the range −30..31;
  - significand {1, frac};
  - rm.
- Stage 2 (align/round) works as follows:
  - Normal, E≥9: magnitude = sig << (E−9). The result is exact.
  - Normal, 0≤E<9: magnitude = sig >> (9−E). The guard bit is the MSB of the discarded bits; sticky is the OR of the rest.
  - Normal, E<0: magnitude = 0. Guard = (E==−1); sticky = 1 if E<−1, otherwise the OR of the fraction bits.
  - The increment depends on rm:
    - RNE: guard && (sticky || mag[0]).
    - RTZ: 0.
    - RDN: sign && (guard||sticky).
    - RUP: !sign && (guard||sticky).
  - Rounded magnitude is held in 33 bits.
- Stage 3 (saturate/sign) works as follows:
  - Positive overflow: mag > 2^(INT_W−1)−1. The result is 2^(INT_W−1)−1 and invalid is set.
  - Negative overflow: mag > 2^(INT_W−1). The result is −2^(INT_W−1) and invalid is set.
  - Special operand: the result saturates by sign and invalid is set.
  - Zero class: the result is 0, with no flags.
  - Otherwise the output is sign ? −mag : mag, and inexact = guard||sticky.
  - For INT_W ≥ 33, only special operands can saturate.
- Each stage has a valid bit.
  - A stage loads when it is empty, or when its contents move forward in the same cycle.
  - in_ready = !v1 || (stage 1 advancing). This is a combinational ready chain from out_ready.
  - Bubbles collapse, and no valid operand is dropped or duplicated.
- When out_valid is high and out_ready is low, the following hold stable until transfer: out_data, out_invalid, out_inexact.

## Timing
- Latency is 3 cycles from an input transfer to out_valid, when there is no stall.
- Throughput is 1 operand per cycle while out_ready stays high.
- Reset values:
  - All stage valids are 0, so out_valid = 0.
  - out_data = 0, out_invalid = 0, out_inexact = 0.
  - in_ready = 1 one cycle after reset deasserts. in_ready is combinationally 1 while the pipeline is empty.
- Asserting rst_n low mid-stream discards all in-flight operands immediately, and no partial result appears.
- Capacity is 3 operands. With out_ready low, in_ready falls after 3 accepted operands and rises in the same cycle that out_ready returns.
- A simultaneous input and output transfer at full occupancy is legal and keeps the pipeline full.

## Configuration
- Macro: `DLF16_TO_INT_FLAGS_EN`.
- When defined: guard/sticky/invalid tracking is implemented and `out_invalid`/`out_inexact` behave as described above.
- When undefined:
  - Both flag outputs are tied to 0.
  - The flag pipeline registers are removed.
  - Saturation and rounding results are unchanged.

## Test plan
- INT_W=32, RNE, operands 0x3E00, 0x3F00, 0x4080, 0x3D00 streamed back-to-back with out_ready=1. Required results: 1, 2, 2, 1, each 3 cycles after its input. 0x3E00 is exact; the other three set inexact.
- Rounding modes on 0xC080 (−2.5). Required results: RTZ −2, RDN −3, RUP −2, RNE −2, all inexact. 0x3C00 (0.5) gives RUP 1, RNE 0, RDN 0.
- Saturation at INT_W=32:
  - 0x7C00 (2^31) gives 0x7FFFFFFF with invalid set.
  - 0xFC00 gives 0x80000000 with no flags.
  - 0x7FFF gives 0x7FFFFFFF with invalid set.
  - 0xFFFF gives 0x80000000 with invalid set.
  - 0x0123 gives 0 with no flags.
- Backpressure: send 5 operands and hold out_ready=0. Required: in_ready drops after the 3rd operand. Then release out_ready for one cycle every other cycle. Required: all 5 results appear in order, and data is held stable while stalled.
- Reset: assert rst_n low with 2 operands in flight. Required: out_valid=0 immediately, and no stale output after release.
- Build with `DLF16_TO_INT_FLAGS_EN` undefined, at INT_W=64. Required: 0x7C00 gives 0x0000000080000000, and both flags stay 0 for every input.
